// File: rtl/bus_pkg.sv
// Shared types and constants for the data-memory bus router.
// Holds the FSM state enum, port-count constants and the port select decode.
package bus_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} bus_demux_state_t;

    localparam int BUS_DEMUX_PORTS = 4;
    localparam int BUS_SEL_WIDTH   = 2;

    function automatic logic [BUS_DEMUX_PORTS-1:0] port_onehot(input logic [BUS_SEL_WIDTH-1:0] sel);
        port_onehot      = '0;
        port_onehot[sel] = 1'b1;
    endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Saturating cycle counter for the ISSUE phase.
// expired flags the enabled cycle on which the count reaches LIMIT.
module bus_timeout_counter #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);
    localparam logic [W-1:0] MAX  = W'(LIMIT);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear)
            cnt <= '0;
        else if (enable && cnt != MAX)
            cnt <= cnt + 1'b1;
    end

    // Looks one increment ahead so the strobe lasts exactly LIMIT cycles.
    assign expired = enable && (cnt >= LAST);

endmodule

// File: rtl/bus_demux_4port.sv
// Single-initiator to four-responder bus router: latches one request, steers it
// to the selected port, and completes on responder ready or timeout.
module bus_demux_4port
    import bus_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic [1:0]                                   control,
    input  logic                                         up_read,
    input  logic                                         up_write,
    input  logic [ADDR_WIDTH-1:0]                        up_address,
    input  logic [DATA_WIDTH-1:0]                        up_writedata,
    input  logic [DATA_WIDTH/8-1:0]                      up_byteenable,
    output logic                                         up_waitrequest,
    output logic [DATA_WIDTH-1:0]                        up_readdata,
    output logic                                         up_error,
    output logic [3:0]                                   dn_read,
    output logic [3:0]                                   dn_write,
    output logic [ADDR_WIDTH-1:0]                        dn_address,
    output logic [DATA_WIDTH-1:0]                        dn_writedata,
    output logic [DATA_WIDTH/8-1:0]                      dn_byteenable,
    input  logic [3:0]                                   dn_waitrequest,
    input  logic [BUS_DEMUX_PORTS-1:0][DATA_WIDTH-1:0]   dn_readdata
);

    bus_demux_state_t           state;
    logic [BUS_SEL_WIDTH-1:0]   sel;
    logic                       is_write;
    logic                       expired;
    logic [BUS_DEMUX_PORTS-1:0] req_hot;

    assign req_hot = port_onehot(control);

    bus_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (state == IDLE),
        .enable  (state == ISSUE),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            sel            <= '0;
            is_write       <= 1'b0;
            dn_address     <= '0;
            dn_writedata   <= '0;
            dn_byteenable  <= '0;
            dn_read        <= '0;
            dn_write       <= '0;
            up_waitrequest <= 1'b1;
            up_readdata    <= '0;
            up_error       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Write wins when both strobes are high.
                    if (up_read || up_write) begin
                        sel           <= control;
                        is_write      <= up_write;
                        dn_address    <= up_address;
                        dn_writedata  <= up_writedata;
                        dn_byteenable <= up_byteenable;
                        dn_read       <= up_write ? '0 : req_hot;
                        dn_write      <= up_write ? req_hot : '0;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Responder completion takes priority over a same-cycle timeout.
                    if (!dn_waitrequest[sel]) begin
                        up_readdata    <= is_write ? '0 : dn_readdata[sel];
                        up_error       <= 1'b0;
                        dn_read        <= '0;
                        dn_write       <= '0;
                        up_waitrequest <= 1'b0;
                        state          <= DONE;
                    end else if (expired) begin
                        up_readdata    <= '0;
                        up_error       <= 1'b1;
                        dn_read        <= '0;
                        dn_write       <= '0;
                        up_waitrequest <= 1'b0;
                        state          <= DONE;
                    end
                end
                DONE: begin
                    up_waitrequest <= 1'b1;
                    up_error       <= 1'b0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_demux_4port.sv
// Randomized scoreboard bench for bus_demux_4port: the driver pushes expected
// completions, a negedge monitor checks strobes, latency, data and error.
module tb_bus_demux_4port;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 6;

    logic                clk = 1'b0;
    logic                reset;
    logic [1:0]          control;
    logic                up_read, up_write;
    logic [AW-1:0]       up_address;
    logic [DW-1:0]       up_writedata;
    logic [DW/8-1:0]     up_byteenable;
    logic                up_waitrequest;
    logic [DW-1:0]       up_readdata;
    logic                up_error;
    logic [3:0]          dn_read, dn_write;
    logic [AW-1:0]       dn_address;
    logic [DW-1:0]       dn_writedata;
    logic [DW/8-1:0]     dn_byteenable;
    logic [3:0]          dn_waitrequest;
    logic [3:0][DW-1:0]  dn_readdata;

    bus_demux_4port #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .control(control),
        .up_read(up_read), .up_write(up_write), .up_address(up_address),
        .up_writedata(up_writedata), .up_byteenable(up_byteenable),
        .up_waitrequest(up_waitrequest), .up_readdata(up_readdata), .up_error(up_error),
        .dn_read(dn_read), .dn_write(dn_write), .dn_address(dn_address),
        .dn_writedata(dn_writedata), .dn_byteenable(dn_byteenable),
        .dn_waitrequest(dn_waitrequest), .dn_readdata(dn_readdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // One expected transaction: strobe window [acc, acc+k), completion at acc+k.
    typedef struct {
        int          port;
        bit          wr;
        logic [31:0] addr, wdata, rdata;
        logic [3:0]  be;
        bit          err;
        int          acc;
        int          k;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor
    exp_t       e;
    logic [3:0] es_r, es_w;
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            es_r = '0;
            es_w = '0;
            if (sbq.size() > 0 && cyc >= sbq[0].acc && cyc < sbq[0].acc + sbq[0].k) begin
                if (sbq[0].wr) es_w[sbq[0].port] = 1'b1;
                else           es_r[sbq[0].port] = 1'b1;
                chk("dn_address", 64'(dn_address), 64'(sbq[0].addr));
                chk("dn_writedata", 64'(dn_writedata), 64'(sbq[0].wdata));
                chk("dn_byteenable", 64'(dn_byteenable), 64'(sbq[0].be));
            end
            chk("dn_read", 64'(dn_read), 64'(es_r));
            chk("dn_write", 64'(dn_write), 64'(es_w));
            if (!up_waitrequest) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_completion", 64'(1), 64'(0));
                end else begin
                    e = sbq.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(e.acc + e.k));
                    chk("up_readdata", 64'(up_readdata), 64'(e.rdata));
                    chk("up_error", 64'(up_error), 64'(e.err));
                end
            end else begin
                chk("up_error_quiet", 64'(up_error), 64'(0));
            end
        end
    end

    // Reference model: completion at ISSUE cycle stall+1 unless that exceeds TO.
    task automatic run_txn(input bit rd, input bit wr, input int port, input int stall,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input logic [31:0] rdata, input bit scramble);
        exp_t x;
        bit   timed_out;
        timed_out      = (stall >= TO);
        up_read        = rd;
        up_write       = wr;
        control        = 2'(port);
        up_address     = addr;
        up_writedata   = wdata;
        up_byteenable  = be;
        dn_waitrequest = 4'($urandom);
        x.port  = port;
        x.wr    = wr;
        x.addr  = addr;
        x.wdata = wdata;
        x.be    = be;
        x.err   = timed_out;
        x.rdata = (wr || timed_out) ? 32'h0 : rdata;
        x.acc   = cyc + 1;
        x.k     = timed_out ? TO : stall + 1;
        sbq.push_back(x);
        @(posedge clk); #1;
        for (int i = 1; ; i++) begin
            dn_waitrequest       = 4'($urandom);
            dn_waitrequest[port] = (i <= stall);
            for (int p = 0; p < 4; p++) dn_readdata[p] = $urandom;
            dn_readdata[port] = rdata;
            if (scramble) begin
                control       = 2'($urandom);
                up_address    = $urandom;
                up_writedata  = $urandom;
                up_byteenable = 4'($urandom);
            end
            @(posedge clk); #1;
            if (!up_waitrequest) break;
            if (i > TO + 4) begin
                chk("completion_timeout", 64'(1), 64'(0));
                break;
            end
        end
        up_read  = 1'b0;
        up_write = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        reset          = 1'b1;
        control        = '0;
        up_read        = 1'b0;
        up_write       = 1'b0;
        up_address     = '0;
        up_writedata   = '0;
        up_byteenable  = '0;
        dn_waitrequest = '0;
        dn_readdata    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_waitrequest", 64'(up_waitrequest), 64'(1));
        chk("rst_readdata", 64'(up_readdata), 64'(0));
        chk("rst_error", 64'(up_error), 64'(0));
        chk("rst_dn_read", 64'(dn_read), 64'(0));
        chk("rst_dn_write", 64'(dn_write), 64'(0));
        chk("rst_dn_address", 64'(dn_address), 64'(0));
        chk("rst_dn_writedata", 64'(dn_writedata), 64'(0));
        chk("rst_dn_byteenable", 64'(dn_byteenable), 64'(0));
        reset  = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;

        run_txn(1, 0, 2, 0,      32'h1000, 32'h0,        4'hF, 32'hDEADBEEF, 0);
        run_txn(0, 1, 0, 5,      32'h2000, 32'h12345678, 4'h3, 32'hCAFEF00D, 0);
        run_txn(1, 0, 3, 100,    32'h3000, 32'h0,        4'hF, 32'h55AA55AA, 0);
        run_txn(1, 0, 1, 3,      32'h40,   32'h0,        4'hF, 32'hA5A5A5A5, 1);
        run_txn(1, 1, 1, 2,      32'h50,   32'h9,        4'h8, 32'h77777777, 0);
        run_txn(1, 0, 2, TO - 1, 32'h60,   32'h0,        4'hF, 32'h0BADF00D, 0);
        run_txn(0, 1, 2, TO,     32'h70,   32'h1,        4'h1, 32'h11111111, 0);

        // Reset during ISSUE drops the transaction without completion.
        mon_en        = 1'b0;
        up_read       = 1'b1;
        control       = 2'd1;
        up_address    = 32'h44;
        dn_waitrequest = 4'hF;
        @(posedge clk); #1;
        chk("pre_rst_dn_read", 64'(dn_read), 64'(4'b0010));
        reset   = 1'b1;
        up_read = 1'b0;
        @(posedge clk); #1;
        chk("midrst_dn_read", 64'(dn_read), 64'(0));
        chk("midrst_dn_write", 64'(dn_write), 64'(0));
        chk("midrst_waitrequest", 64'(up_waitrequest), 64'(1));
        chk("midrst_error", 64'(up_error), 64'(0));
        reset  = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;
        run_txn(1, 0, 0, 0, 32'h88, 32'h0, 4'hF, 32'h600DCAFE, 0);

        for (int n = 0; n < 200; n++) begin
            bit rd, wr;
            rd = $urandom_range(0, 1);
            wr = $urandom_range(0, 1);
            if (!rd && !wr) rd = 1'b1;
            run_txn(rd, wr, $urandom_range(0, 3), $urandom_range(0, TO + 2),
                    $urandom, $urandom, 4'($urandom), $urandom, $urandom_range(0, 1));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 64'(sbq.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
